aes_key_sched_ctrl: RTL and testbench
=====================================

Name: aes_key_sched_ctrl

Overview:
- Sequencer for the single-round KeyExpansion datapath.
- On a start pulse, iterates KeyExpansion once per clock to build all 11 AES-128 round keys from a cipher key (encrypt) or from the final round key (decrypt).
- Holds the keys in an 11-entry register file indexed by round number. The round pipeline reads it through a registered read port.
- Sits between the host key-load interface and the AES round datapath.

Parameters:
- NUM_ROUNDS, 10, number of expansion steps; register file depth is NUM_ROUNDS+1.
- KEY_W, 128, round key width; fixed for AES-128, not to be overridden.

Ports:
- i_Clk  input  1  system clock; all state updates on the rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Start  input  1  one-cycle request to begin expansion; accepted only in IDLE or DONE.
- i_Key  input  128  seed key, sampled in the cycle i_Start is accepted.
- i_fDec  input  1  0 = seed is cipher key (round 0); 1 = seed is round-10 key. Sampled with i_Start.
- i_RdAddr  input  4  round-key index to read, 0..10.
- o_RdKey  output  128  registered round key for i_RdAddr.
- o_Busy  output  1  high while expansion is in progress.
- o_Ready  output  1  high when all 11 slots hold a consistent set of round keys.
- o_Done  output  1  one-cycle pulse when the final slot is written.

Behaviour:
- Reset (i_Rst_n low, asynchronous):
  - All 11 slots = 0; round counter = 0; state = IDLE.
  - o_RdKey = 0, o_Busy = 0, o_Ready = 0, o_Done = 0.
  - Reset during EXPAND aborts the expansion. No partial keys survive.
- States:
  - IDLE: i_Start moves to EXPAND.
  - EXPAND: runs NUM_ROUNDS steps, then moves to DONE.
  - DONE: i_Start moves to EXPAND.
- Start cycle (cycle 0), i_Start accepted:
  - Latch i_fDec into a mode register. The mode is held constant for the whole expansion.
  - Encrypt: write i_Key to slot 0 and to the working register.
  - Decrypt: write i_Key to slot 10 and to the working register.
  - o_Busy rises and o_Ready falls, both registered (visible from cycle 1).
- Step k (cycles 1..10):
  - Working register feeds KeyExpansion; the result overwrites the working register.
  - Encrypt: i_RoundNum = k; result written to slot k.
  - Decrypt: i_RoundNum = 11-k; KeyExpansion inverts round-key (11-k) to key (10-k); result written to slot 10-k.
  - Exactly one slot is written per cycle.
- Completion:
  - The last write is in cycle 10.
  - o_Done pulses high in cycle 11.
  - In cycle 11, o_Busy goes low and o_Ready goes high.
  - Start-to-Done latency = 11 cycles.
- i_Start while o_Busy: ignored. No restart and no change to the mode or seed.
- i_Start in DONE: o_Ready drops in the next cycle. Slots are overwritten progressively. Readers must wait for o_Ready.
- Read port:
  - o_RdKey <= slot[i_RdAddr] every cycle, regardless of state (1-cycle latency).
  - i_RdAddr 11..15 returns 0.
  - Read during EXPAND returns current slot contents, which may be old or new. o_Ready is low in that window.
- Read and write of the same slot in one cycle: o_RdKey returns the pre-write value.
- Round counter is 4 bits and counts 0..10. It never wraps; it is cleared on start.

Optional Feature:
- Macro: KEYSCHED_ZEROIZE_EN.
- Defined:
  - Adds input port i_Zeroize (1 bit).
  - When high in any state, in the next cycle: all slots and the working register = 0, state = IDLE, o_Busy = 0, o_Ready = 0, o_Done = 0, o_RdKey = 0.
  - i_Zeroize has priority over a simultaneous i_Start.
- Not defined: port absent; slot contents change only via reset or a new expansion.

Test Plan:
- Encrypt FIPS-197: i_Key=2b7e151628aed2a6abf7158809cf4f3c, i_fDec=0, pulse i_Start.
  - o_Done exactly 11 cycles later.
  - Slot 1 = a0fafe1788542cb123a339392a6c7605.
  - Slot 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - All 11 keys match the golden model.
- Decrypt: i_Key=d014f9a8c9ee2589e13f0cc8b6630ca6, i_fDec=1.
  - Slot 0 = 2b7e151628aed2a6abf7158809cf4f3c.
  - All slots identical to the encrypt run.
- i_Start pulsed again at cycle 5 of an expansion: ignored. Done still at cycle 11; keys unchanged from the first seed.
- Reset asserted at cycle 6 of an expansion: all outputs 0 immediately. After release, o_Ready stays 0 and reads of slots 0..10 return 0.
- Read port checks:
  - i_RdAddr=12 returns 0.
  - i_RdAddr=3 after Done returns slot 3 one cycle later.
  - Restart from DONE drops o_Ready within 1 cycle.
- With KEYSCHED_ZEROIZE_EN: i_Zeroize and i_Start asserted in the same cycle in DONE. Next cycle: state IDLE, every read returns 0, no o_Done pulse follows.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule sequencer: one KeyExpansion step per clock into an 11-slot round-key file.
// Latency: start to o_Done is 11 cycles; the read port is registered (1 cycle). No backpressure; i_Start is dropped while busy.
// Optional KEYSCHED_ZEROIZE_EN adds i_Zeroize, which clears all key material and returns to IDLE.
module aes_key_sched_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int KEY_W      = 128
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
`ifdef KEYSCHED_ZEROIZE_EN
    input  logic             i_Zeroize,
`endif
    input  logic             i_Start,
    input  logic [KEY_W-1:0] i_Key,
    input  logic             i_fDec,
    input  logic [3:0]       i_RdAddr,
    output logic [KEY_W-1:0] o_RdKey,
    output logic             o_Busy,
    output logic             o_Ready,
    output logic             o_Done
);

    typedef enum logic [1:0] {ST_IDLE, ST_EXPAND, ST_DONE} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as x^254 in GF(2^8) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(rnd), 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0]  ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Undo one step: recover the previous words back-to-front, then word 0 needs the recovered word 3.
    function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0]  ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rcon(rnd), 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [KEY_W-1:0] work_q, work_d;
    logic             busy_q, busy_d, ready_q, ready_d, done_q, done_d;
    logic             wr_en, clr, zeroize;
    logic [3:0]       wr_idx, step_rnd;
    logic [KEY_W-1:0] wr_dat, step_key, rd_q;
    logic [KEY_W-1:0] slot_q [0:NUM_ROUNDS];

`ifdef KEYSCHED_ZEROIZE_EN
    assign zeroize = i_Zeroize;
`else
    assign zeroize = 1'b0;
`endif

    assign step_rnd = mode_q ? 4'(NUM_ROUNDS) - cnt_q : cnt_q + 4'd1;
    assign step_key = mode_q ? key_inv(work_q, step_rnd) : key_fwd(work_q, step_rnd);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        work_d  = work_q;
        busy_d  = busy_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = '0;
        wr_dat  = '0;
        clr     = 1'b0;
        if (zeroize) begin
            clr     = 1'b1;
            state_d = ST_IDLE;
            cnt_d   = '0;
            mode_d  = 1'b0;
            work_d  = '0;
            busy_d  = 1'b0;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_Start) begin
                        state_d = ST_EXPAND;
                        cnt_d   = '0;
                        mode_d  = i_fDec;
                        work_d  = i_Key;
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                        wr_en   = 1'b1;
                        wr_idx  = i_fDec ? 4'(NUM_ROUNDS) : 4'd0;
                        wr_dat  = i_Key;
                    end
                end
                ST_EXPAND: begin
                    work_d = step_key;
                    cnt_d  = cnt_q + 4'd1;
                    wr_en  = 1'b1;
                    wr_idx = mode_q ? 4'(NUM_ROUNDS - 1) - cnt_q : cnt_q + 4'd1;
                    wr_dat = step_key;
                    if (cnt_q == 4'(NUM_ROUNDS - 1)) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        ready_d = 1'b1;
                        done_d  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            work_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // Read samples the pre-write slot value when the same slot is written this cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
            rd_q <= '0;
        end else begin
            if (clr || i_RdAddr > 4'(NUM_ROUNDS)) rd_q <= '0;
            else                                  rd_q <= slot_q[i_RdAddr];
            if (clr) begin
                for (int i = 0; i <= NUM_ROUNDS; i++) slot_q[i] <= '0;
            end else if (wr_en) begin
                slot_q[wr_idx] <= wr_dat;
            end
        end
    end

    assign o_RdKey = rd_q;
    assign o_Busy  = busy_q;
    assign o_Ready = ready_q;
    assign o_Done  = done_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl against the FIPS-197 AES-128 key schedule.
module tb_aes_key_sched_ctrl;

    logic         i_Clk = 1'b0;
    logic         i_Rst_n;
    logic         i_Start;
    logic [127:0] i_Key;
    logic         i_fDec;
    logic [3:0]   i_RdAddr;
    logic [127:0] o_RdKey;
    logic         o_Busy, o_Ready, o_Done;
`ifdef KEYSCHED_ZEROIZE_EN
    logic         i_Zeroize;
`endif

    aes_key_sched_ctrl dut (
        .i_Clk    (i_Clk),
        .i_Rst_n  (i_Rst_n),
`ifdef KEYSCHED_ZEROIZE_EN
        .i_Zeroize(i_Zeroize),
`endif
        .i_Start  (i_Start),
        .i_Key    (i_Key),
        .i_fDec   (i_fDec),
        .i_RdAddr (i_RdAddr),
        .o_RdKey  (o_RdKey),
        .o_Busy   (o_Busy),
        .o_Ready  (o_Ready),
        .o_Done   (o_Done)
    );

    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] exp;
    } vec_t;

    logic [127:0] fips [0:10];
    vec_t         tab  [0:12];
    int           n_cmp = 0;
    int           n_bad = 0;

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b, want %0b", name, act, exp);
        end
    endtask

    // Pulses start, optionally re-pulses it with a junk seed at edge count inject_at, returns edges to o_Done.
    task automatic run_expand(input logic [127:0] key, input logic dec, input int inject_at, output int lat);
        i_Key   = key;
        i_fDec  = dec;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        i_Key   = '0;
        lat     = 1;
        while (!o_Done && lat < 20) begin
            if (lat == inject_at) begin
                i_Start = 1'b1;
                i_Key   = {4{32'hdeadbeef}};
                i_fDec  = ~dec;
            end
            tick();
            i_Start = 1'b0;
            lat++;
        end
    endtask

    task automatic apply_table(input string tag);
        for (int i = 0; i <= 12; i++) begin
            i_RdAddr = tab[i].addr;
            tick();
            chk($sformatf("%s_rd%0d", tag, tab[i].addr), o_RdKey, tab[i].exp);
        end
    endtask

    initial begin
        int lat;
        fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
        fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i <= 10; i++) begin
            tab[i].addr = 4'(i);
            tab[i].exp  = fips[i];
        end
        tab[11].addr = 4'd12; tab[11].exp = '0;
        tab[12].addr = 4'd15; tab[12].exp = '0;

        i_Rst_n = 1'b0; i_Start = 1'b0; i_Key = '0; i_fDec = 1'b0; i_RdAddr = 4'd0;
`ifdef KEYSCHED_ZEROIZE_EN
        i_Zeroize = 1'b0;
`endif
        #12;
        chk("rst_rdkey", o_RdKey, '0);
        chk1("rst_busy", o_Busy, 1'b0);
        chk1("rst_ready", o_Ready, 1'b0);
        chk1("rst_done", o_Done, 1'b0);
        i_Rst_n = 1'b1;
        tick();

        // Encrypt from the FIPS-197 cipher key.
        i_Key = fips[0]; i_fDec = 1'b0; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        chk1("enc_busy_c1", o_Busy, 1'b1);
        chk1("enc_ready_c1", o_Ready, 1'b0);
        lat = 1;
        while (!o_Done && lat < 20) begin
            tick();
            lat++;
        end
        chk("enc_latency", 128'(lat), 128'd11);
        chk1("enc_busy_done", o_Busy, 1'b0);
        chk1("enc_ready_done", o_Ready, 1'b1);
        tick();
        chk1("enc_done_pulse", o_Done, 1'b0);
        apply_table("enc");

        i_RdAddr = 4'd12;
        tick();
        i_RdAddr = 4'd3;
        #1;
        chk("rd3_before_edge", o_RdKey, '0);
        tick();
        chk("rd3_after_edge", o_RdKey, fips[3]);

        // Restart from DONE with a stray start mid-expansion.
        i_Key = fips[0]; i_fDec = 1'b0; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        chk1("restart_ready_drop", o_Ready, 1'b0);
        chk1("restart_busy", o_Busy, 1'b1);
        lat = 1;
        while (!o_Done && lat < 20) begin
            if (lat == 5) begin
                i_Start = 1'b1; i_Key = {4{32'hdeadbeef}}; i_fDec = 1'b1;
            end
            tick();
            i_Start = 1'b0;
            lat++;
        end
        chk("ignore_latency", 128'(lat), 128'd11);
        apply_table("ign");

        // Reset mid-expansion, six edges after start.
        i_Key = fips[0]; i_fDec = 1'b0; i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        repeat (5) tick();
        #2;
        i_Rst_n = 1'b0;
        #1;
        chk("midrst_rdkey", o_RdKey, '0);
        chk1("midrst_busy", o_Busy, 1'b0);
        chk1("midrst_ready", o_Ready, 1'b0);
        chk1("midrst_done", o_Done, 1'b0);
        #3;
        i_Rst_n = 1'b1;
        tick();
        chk1("postrst_ready", o_Ready, 1'b0);
        for (int i = 0; i <= 10; i++) begin
            i_RdAddr = 4'(i);
            tick();
            chk($sformatf("postrst_rd%0d", i), o_RdKey, '0);
        end
        chk1("postrst_ready_late", o_Ready, 1'b0);

        // Decrypt from the round-10 key into an empty key file.
        run_expand(fips[10], 1'b1, -1, lat);
        chk("dec_latency", 128'(lat), 128'd11);
        chk1("dec_ready", o_Ready, 1'b1);
        apply_table("dec");

`ifdef KEYSCHED_ZEROIZE_EN
        i_Zeroize = 1'b1; i_Start = 1'b1; i_Key = fips[0]; i_fDec = 1'b0;
        tick();
        i_Zeroize = 1'b0; i_Start = 1'b0;
        chk1("zero_busy", o_Busy, 1'b0);
        chk1("zero_ready", o_Ready, 1'b0);
        chk1("zero_done", o_Done, 1'b0);
        chk("zero_rdkey", o_RdKey, '0);
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int i = 0; i <= 12; i++) begin
                i_RdAddr = tab[i].addr;
                tick();
                saw_done = saw_done | o_Done;
                chk($sformatf("zero_rd%0d", tab[i].addr), o_RdKey, '0);
            end
            chk1("zero_no_done", saw_done, 1'b0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
